// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control/result bundle between the control unit, the PC
// sequencer and instruction memory. The master side (control unit or bench)
// drives the request fields; the slave side (pc_seq_unit) drives the PC view.
interface pc_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             PCWre;
    logic [1:0]       PCSrc;
    logic             branchTaken;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] jumpTarget;
    logic             isCall;
    logic             exception;
    logic             eret;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] pcPlus;
    logic [WIDTH-1:0] epc;
    logic [1:0]       state;
    logic             rasEmpty;
    logic             rasFull;
    logic             rasErr;
    logic             alignFault;

    modport master (
        output PCWre, PCSrc, branchTaken, immediate, jumpTarget, isCall, exception, eret,
        input  result, pcPlus, epc, state, rasEmpty, rasFull, rasErr, alignFault
    );

    modport slave (
        input  PCWre, PCSrc, branchTaken, immediate, jumpTarget, isCall, exception, eret,
        output result, pcPlus, epc, state, rasEmpty, rasFull, rasErr, alignFault
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with return-address stack and
// exception redirect / EPC save-restore.
// Optional build macro PC_ALIGN_CHECK_EN: when defined, every loaded PC has its
// low log2(STEP) bits cleared and alignFault pulses for one cycle after a
// misaligned load; when undefined, targets load unmodified and alignFault is 0.
module pc_seq_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    pc_seq_unit_if.slave  bus
);
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_EXC  = 2'b10
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_epc;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]   r_wp;        // next free slot; top of stack is r_wp-1
    logic [COUNT_W-1:0] r_count;
    logic               r_ras_err;

    logic [WIDTH-1:0]   w_seq;
    logic [WIDTH-1:0]   w_next;
    logic [WIDTH-1:0]   w_target;
    logic [WIDTH-1:0]   w_load_val;
    logic               w_push;
    logic               w_pop;
    logic               w_pop_empty;
    logic               w_take_exc;
    logic               w_take_eret;
    logic               w_normal;
    logic               w_load_en;
    logic               w_ras_full;

`ifdef PC_ALIGN_CHECK_EN
    localparam int               ALIGN_LOW  = (STEP > 1) ? $clog2(STEP) : 0;
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_LOW) - WIDTH'(1));

    function automatic logic [WIDTH-1:0] f_align_pc(input logic [WIDTH-1:0] v);
        return v & ALIGN_MASK;
    endfunction

    function automatic logic f_misaligned(input logic [WIDTH-1:0] v);
        return |(v & ~ALIGN_MASK);
    endfunction

    logic r_align_fault;
`endif

    assign w_ras_full = (r_count == COUNT_W'(RAS_DEPTH));

    // Next-PC candidate from PCSrc plus the RAS action it implies
    always_comb begin
        w_seq       = r_pc + WIDTH'(STEP);
        w_next      = w_seq;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_pop_empty = 1'b0;
        case (bus.PCSrc)
            2'b00: w_next = w_seq;
            2'b01: begin
                if (bus.branchTaken) begin
                    w_next = w_seq + (bus.immediate << 2);
                end else begin
                    w_next = w_seq;
                end
            end
            2'b10: begin
                w_next = bus.jumpTarget;
                w_push = bus.isCall;
            end
            2'b11: begin
                if (r_count == COUNT_W'(0)) begin
                    w_next      = w_seq;
                    w_pop_empty = 1'b1;
                end else begin
                    w_next = r_ras[r_wp - PTR_W'(1)];
                    w_pop  = 1'b1;
                end
            end
            default: w_next = w_seq;
        endcase
    end

    // Edge decision: exception beats eret beats the normal PCSrc update
    always_comb begin
        w_take_exc  = (r_state == ST_RUN) && bus.exception;
        w_take_eret = (r_state == ST_EXC) && bus.PCWre && bus.eret;
        w_normal    = ((r_state == ST_RUN) || (r_state == ST_EXC)) && bus.PCWre
                      && !w_take_exc && !w_take_eret;
        w_load_en   = w_take_exc | w_take_eret | w_normal;
        if (w_take_exc) begin
            w_target = EXC_VECTOR;
        end else if (w_take_eret) begin
            w_target = r_epc;
        end else begin
            w_target = w_next;
        end
`ifdef PC_ALIGN_CHECK_EN
        w_load_val = f_align_pc(w_target);
`else
        w_load_val = w_target;
`endif
    end

    // Sequencer FSM, PC/EPC registers and return-address stack
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_VECTOR;
            r_epc     <= '0;
            r_wp      <= '0;
            r_count   <= '0;
            r_ras_err <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_take_exc) r_state <= ST_EXC;
                    else            r_state <= ST_RUN;
                end
                ST_EXC: begin
                    if (w_take_eret) r_state <= ST_RUN;
                    else             r_state <= ST_EXC;
                end
                default: r_state <= ST_BOOT;
            endcase

            if (w_load_en) r_pc <= w_load_val;
            if (w_take_exc) r_epc <= r_pc;

            if (w_normal) begin
                if (w_push) begin
                    // Circular buffer: a push when full overwrites the oldest entry
                    r_ras[r_wp] <= w_seq;
                    r_wp        <= r_wp + PTR_W'(1);
                    if (w_ras_full) r_ras_err <= 1'b1;
                    else            r_count   <= r_count + COUNT_W'(1);
                end else if (w_pop) begin
                    r_wp    <= r_wp - PTR_W'(1);
                    r_count <= r_count - COUNT_W'(1);
                end else if (w_pop_empty) begin
                    r_ras_err <= 1'b1;
                end
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle pulse after any load whose target had low bits set
    always_ff @(posedge CLK) begin
        if (Reset) r_align_fault <= 1'b0;
        else       r_align_fault <= w_load_en & f_misaligned(w_target);
    end
    assign bus.alignFault = r_align_fault;
`else
    assign bus.alignFault = 1'b0;
`endif

    assign bus.result   = r_pc;
    assign bus.pcPlus   = r_pc + WIDTH'(STEP);
    assign bus.epc      = r_epc;
    assign bus.state    = r_state;
    assign bus.rasEmpty = (r_count == COUNT_W'(0));
    assign bus.rasFull  = w_ras_full;
    assign bus.rasErr   = r_ras_err;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed table vectors, hand-written RAS/alignment sequences
// and a randomized phase, all compared each cycle against a queue-based model.
module tb_pc_seq_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;

    pc_seq_unit_if #(.WIDTH(32)) bus ();

    pc_seq_unit #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .STEP(4), .RAS_DEPTH(4)
    ) dut (
        .CLK(clk), .Reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_st;
    logic [31:0] m_ras[$];
    logic        m_err, m_af;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_load(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
        m_pc = v & ~32'h3;
        m_af = (v[1:0] != 2'b00);
`else
        m_pc = v;
`endif
    endtask

    // Spec-level next state for the coming edge, from the current inputs
    task automatic model_edge();
        logic [31:0] seq;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_st = 2'b00; m_ras.delete(); m_err = 1'b0; m_af = 1'b0;
        end else begin
            m_af = 1'b0;
            seq  = m_pc + 32'd4;
            if (m_st == 2'b00) begin
                m_st = 2'b01;
            end else if (m_st == 2'b01 && bus.exception) begin
                m_epc = m_pc; model_load(32'h80); m_st = 2'b10;
            end else if (m_st == 2'b10 && bus.PCWre && bus.eret) begin
                model_load(m_epc); m_st = 2'b01;
            end else if (bus.PCWre) begin
                case (bus.PCSrc)
                    2'b00: model_load(seq);
                    2'b01: model_load(bus.branchTaken ? seq + (bus.immediate << 2) : seq);
                    2'b10: begin
                        if (bus.isCall) begin
                            m_ras.push_back(seq);
                            if (m_ras.size() > 4) begin
                                void'(m_ras.pop_front());
                                m_err = 1'b1;
                            end
                        end
                        model_load(bus.jumpTarget);
                    end
                    default: begin
                        if (m_ras.size() == 0) begin
                            m_err = 1'b1; model_load(seq);
                        end else begin
                            model_load(m_ras.pop_back());
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("result",     bus.result,              m_pc);
        chk("pcPlus",     bus.pcPlus,              m_pc + 32'd4);
        chk("epc",        bus.epc,                 m_epc);
        chk("state",      32'(bus.state),          32'(m_st));
        chk("rasEmpty",   32'(bus.rasEmpty),       32'(m_ras.size() == 0));
        chk("rasFull",    32'(bus.rasFull),        32'(m_ras.size() == 4));
        chk("rasErr",     32'(bus.rasErr),         32'(m_err));
        chk("alignFault", 32'(bus.alignFault),     32'(m_af));
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic tk,
                         input logic [31:0] imm, input logic [31:0] tgt,
                         input logic call, input logic exc, input logic er);
        bus.PCWre = we; bus.PCSrc = src; bus.branchTaken = tk; bus.immediate = imm;
        bus.jumpTarget = tgt; bus.isCall = call; bus.exception = exc; bus.eret = er;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  src;
        logic        tk;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        call;
        logic        exc;
        logic        er;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic        e_empty;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] neg2;
        logic [31:0] exp_ret[4];
        logic [31:0] pc_now;
        neg2 = 32'hFFFF_FFFE;
        // {we, src, taken, imm, target, call, exc, eret, exp result, exp state, exp empty, exp epc}
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h00,  2'b01, 1'b1, 32'h00};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h04,  2'b01, 1'b1, 32'h00};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h08,  2'b01, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h0C,  2'b01, 1'b1, 32'h00};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h10,  2'b01, 1'b1, 32'h00};
        vecs[5]  = '{1'b1, 2'd1, 1'b1, neg2,  32'd0,     1'b0, 1'b0, 1'b0, 32'h0C,  2'b01, 1'b1, 32'h00};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h10,  2'b01, 1'b1, 32'h00};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, neg2,  32'd0,     1'b0, 1'b0, 1'b0, 32'h14,  2'b01, 1'b1, 32'h00};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'd0, 32'h20,    1'b0, 1'b0, 1'b0, 32'h20,  2'b01, 1'b1, 32'h00};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'd0, 32'h100,   1'b1, 1'b0, 1'b0, 32'h100, 2'b01, 1'b0, 32'h00};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h24,  2'b01, 1'b1, 32'h00};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'd0, 32'h40,    1'b0, 1'b0, 1'b0, 32'h40,  2'b01, 1'b1, 32'h00};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b1, 1'b0, 32'h80,  2'b10, 1'b1, 32'h40};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b1, 1'b0, 32'h80,  2'b10, 1'b1, 32'h40};
        vecs[14] = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b1, 32'h40,  2'b01, 1'b1, 32'h40};
        vecs[15] = '{1'b1, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b1, 32'h44,  2'b01, 1'b1, 32'h40};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 32'd0, 32'd0,     1'b0, 1'b0, 1'b0, 32'h44,  2'b01, 1'b1, 32'h40};

        // Reset for two edges
        rst = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("reset_result", bus.result, 32'h0);
        chk("reset_state", 32'(bus.state), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].we, vecs[i].src, vecs[i].tk, vecs[i].imm, vecs[i].tgt,
                  vecs[i].call, vecs[i].exc, vecs[i].er);
            cycle();
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].e_pc);
            chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].e_st));
            chk($sformatf("vec%0d_empty", i), 32'(bus.rasEmpty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_epc", i), bus.epc, vecs[i].e_epc);
        end

        // Five calls into a four-deep RAS, then five returns
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd2, 1'b0, 32'd0, 32'h200 + 32'(k) * 32'h10, 1'b1, 1'b0, 1'b0);
            cycle();
            chk("call_target", bus.result, 32'h200 + 32'(k) * 32'h10);
        end
        chk("ras_full_after_5", 32'(bus.rasFull), 32'd1);
        chk("ras_err_after_5", 32'(bus.rasErr), 32'd1);
        for (int k = 0; k < 4; k++) exp_ret[k] = 32'h234 - 32'(k) * 32'h10;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            cycle();
            chk("ret_lifo", bus.result, exp_ret[k]);
        end
        chk("ras_empty_after_4", 32'(bus.rasEmpty), 32'd1);
        drive(1'b1, 2'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("ret_underflow", bus.result, 32'h208);
        chk("ras_err_sticky", 32'(bus.rasErr), 32'd1);

        // Misaligned jump
        drive(1'b1, 2'd2, 1'b0, 32'd0, 32'h103, 1'b0, 1'b0, 1'b0);
        cycle();
`ifdef PC_ALIGN_CHECK_EN
        chk("align_result", bus.result, 32'h100);
        chk("align_pulse", 32'(bus.alignFault), 32'd1);
`else
        chk("align_result", bus.result, 32'h103);
        chk("align_pulse", 32'(bus.alignFault), 32'd0);
`endif
        drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("align_pulse_end", 32'(bus.alignFault), 32'd0);
        pc_now = bus.result;
        drive(1'b1, 2'd2, 1'b0, 32'd0, 32'h300, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("realign", bus.result, 32'h300);
        chk("realign_prev", pc_now + 32'd4, 32'h300 + 32'd4 - 32'h300 + pc_now);

        // Randomized phase against the model
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tgt;
            tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 15)) - 32'd8, tgt, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the multi-cycle CPU; successor to the single-register PC.
- Holds the PC and computes the next PC internally: sequential, relative branch, absolute jump, or return.
- Adds a call/return address stack (RAS) and an exception redirect with EPC save/restore.
- Sits between the control unit (PCWre, PCSrc) and instruction memory (result).

Parameters:
- WIDTH, 32: PC width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value loaded by Reset.
- EXC_VECTOR, 32'h0000_0080: PC value loaded on exception entry.
- STEP, 4: sequential increment in bytes.
- RAS_DEPTH, 4: return-stack entries; must be a power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- PCWre  in  1  PC write enable; 0 = stall.
- PCSrc  in  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 return.
- branchTaken  in  1  branch condition; qualifies PCSrc=01.
- immediate  in  WIDTH  sign-extended word offset for branches.
- jumpTarget  in  WIDTH  absolute target for PCSrc=10.
- isCall  in  1  with PCSrc=10, push the return address.
- exception  in  1  exception request; single-cycle pulse.
- eret  in  1  return from exception.
- result  out  WIDTH  current PC.
- pcPlus  out  WIDTH  result+STEP, combinational.
- epc  out  WIDTH  saved exception PC.
- state  out  2  00 BOOT, 01 RUN, 10 EXC.
- rasEmpty  out  1  RAS holds no entries.
- rasFull  out  1  RAS holds RAS_DEPTH entries.
- rasErr  out  1  sticky flag: RAS overflow or underflow.
- alignFault  out  1  one-cycle misalignment pulse; exists only with the optional feature.

Behaviour:
- Reset (synchronous, overrides everything): result=RESET_VECTOR, epc=0, state=BOOT, RAS count=0, rasErr=0, alignFault=0.
- BOOT: result holds for exactly one cycle, regardless of PCWre and exception; next state RUN.
- RUN/EXC with PCWre=1: result updates on that edge (latency 1). With PCWre=0, result holds and the RAS is unchanged.
- Next-PC rules, all arithmetic modulo 2^WIDTH:
  - 00: result+STEP.
  - 01: result+STEP+(immediate<<2) if branchTaken, else result+STEP.
  - 10: jumpTarget. If isCall=1, also push result+STEP.
  - 11: top of RAS, then pop. If the RAS is empty: result+STEP, set rasErr, count stays 0.
- Push when full: overwrite the oldest entry (circular buffer), set rasErr, count stays RAS_DEPTH.
- isCall is ignored unless PCSrc=10.
- exception in RUN, independent of PCWre: epc<=result, result<=EXC_VECTOR, state->EXC. No RAS change; the normal update that cycle is discarded.
- exception in EXC: ignored; the nested exception is dropped.
- eret in EXC with PCWre=1: result<=epc, state->RUN. eret has priority over PCSrc; no RAS change. eret in RUN is ignored and normal sequencing applies.
- Priority per edge: Reset > exception > eret > PCSrc update.
- rasErr is cleared only by Reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: on any PC load, the bits of the new PC below log2(STEP) are forced to 0. If they were nonzero, alignFault pulses high for 1 cycle following the load.
- Undefined: targets load unmodified and alignFault is tied to 0.

Test Plan:
- Reset high for 2 edges, then low with PCWre=1, PCSrc=00 -> result=0 through the BOOT cycle, then 4, 8, 12; state 00 -> 01.
- Branch at result=0x10 with immediate=-2 and branchTaken=1 -> result=0x0C. Same with branchTaken=0 -> 0x14.
- Call at 0x20: PCSrc=10, isCall=1, jumpTarget=0x100 -> result=0x100, rasEmpty=0. Then PCSrc=11 -> result=0x24, rasEmpty=1.
- 5 calls with RAS_DEPTH=4, then 5 returns -> rasFull=1 and rasErr=1. The 4 newest addresses return in LIFO order; the 5th return yields result+4.
- exception at result=0x40 with PCWre=0 -> result=0x80, epc=0x40, state=EXC. Second exception ignored. eret with PCWre=1 -> result=0x40, state=RUN.
- With PC_ALIGN_CHECK_EN defined: jump to 0x103 -> result=0x100 and alignFault high for 1 cycle. Undefined: result=0x103, alignFault=0.
